// File: rtl/signed_comp.sv
// Registered signed/unsigned magnitude comparator with one-cycle latency.
// Optional min/max outputs are enabled by defining SIGNED_COMP_MINMAX_EN.
module signed_comp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             uns,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             out_valid
`ifdef SIGNED_COMP_MINMAX_EN
   ,output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
`endif
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] diff;
    logic           cmp_lt;
    logic           cmp_eq;
    logic           cmp_gt;

    logic lt_q, lt_d;
    logic gt_q, gt_d;
    logic eq_q, eq_d;
    logic out_valid_q, out_valid_d;
`ifdef SIGNED_COMP_MINMAX_EN
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves a latch behind.
        lt_d        = lt_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        out_valid_d = 1'b0;
`ifdef SIGNED_COMP_MINMAX_EN
        min_d       = min_q;
        max_d       = max_q;
`endif

        // The extra bit makes the difference exact in both modes, so its MSB is the true sign.
        ext_a  = {~uns & a[WIDTH-1], a};
        ext_b  = {~uns & b[WIDTH-1], b};
        diff   = ext_a - ext_b;
        cmp_lt = diff[WIDTH];
        cmp_eq = (diff == '0);
        cmp_gt = ~cmp_lt & ~cmp_eq;

        if (in_valid) begin
            lt_d        = cmp_lt;
            gt_d        = cmp_gt;
            eq_d        = cmp_eq;
            out_valid_d = 1'b1;
`ifdef SIGNED_COMP_MINMAX_EN
            min_d       = cmp_gt ? b : a;
            max_d       = cmp_lt ? b : a;
`endif
        end
    end

    // NOTE: state flops use non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SIGNED_COMP_MINMAX_EN
            min_q       <= '0;
            max_q       <= '0;
`endif
        end else begin
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
`ifdef SIGNED_COMP_MINMAX_EN
            min_q       <= min_d;
            max_q       <= max_d;
`endif
        end
    end

    assign lt        = lt_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign out_valid = out_valid_q;
`ifdef SIGNED_COMP_MINMAX_EN
    assign min_o     = min_q;
    assign max_o     = max_q;
`endif

endmodule

// File: tb/tb_signed_comp.sv
// Self-checking bench for signed_comp: directed vectors plus randomized traffic
// against an arithmetic reference model (min/max checked when SIGNED_COMP_MINMAX_EN is set).
module tb_signed_comp;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         uns;
    logic         lt;
    logic         gt;
    logic         eq;
    logic         out_valid;
`ifdef SIGNED_COMP_MINMAX_EN
    logic [W-1:0] min_o;
    logic [W-1:0] max_o;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: what the outputs should show after the latest edge.
    logic         exp_lt, exp_gt, exp_eq, exp_vld;
    logic [W-1:0] exp_min, exp_max;

    signed_comp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .uns       (uns),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq),
        .out_valid (out_valid)
`ifdef SIGNED_COMP_MINMAX_EN
       ,.min_o     (min_o),
        .max_o     (max_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Interpret an operand as a mathematical integer according to the mode.
    function automatic longint to_num(input logic [W-1:0] v, input logic u);
        if (u) return longint'({32'b0, v});
        return longint'({{32{v[W-1]}}, v});
    endfunction

    task automatic step(input logic r, input logic iv, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic vu, input string tag);
        longint na, nb;
        rst      = r;
        in_valid = iv;
        a        = va;
        b        = vb;
        uns      = vu;
        @(posedge clk);
        #1;
        if (r) begin
            {exp_lt, exp_gt, exp_eq, exp_vld} = 4'b0;
            exp_min = '0;
            exp_max = '0;
        end else if (iv) begin
            na      = to_num(va, vu);
            nb      = to_num(vb, vu);
            exp_lt  = (na < nb);
            exp_gt  = (na > nb);
            exp_eq  = (na == nb);
            exp_vld = 1'b1;
            exp_min = (na <= nb) ? va : vb;
            exp_max = (na >= nb) ? va : vb;
        end else begin
            exp_vld = 1'b0;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_vld));
        check({tag, ".lt"},        64'(lt),        64'(exp_lt));
        check({tag, ".gt"},        64'(gt),        64'(exp_gt));
        check({tag, ".eq"},        64'(eq),        64'(exp_eq));
        if (exp_vld)
            check({tag, ".onehot"}, 64'(32'(lt) + 32'(gt) + 32'(eq)), 64'd1);
`ifdef SIGNED_COMP_MINMAX_EN
        check({tag, ".min"}, 64'(min_o), 64'(exp_min));
        check({tag, ".max"}, 64'(max_o), 64'(exp_max));
`endif
    endtask

    initial begin
        logic [W-1:0] edge_vals [5];
        logic [W-1:0] ra, rb;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h8000_0000;
        edge_vals[2] = 32'h7FFF_FFFF;
        edge_vals[3] = 32'hFFFF_FFFF;
        edge_vals[4] = 32'h0000_0001;

        // Reset with in_valid high: must be ignored.
        step(1'b1, 1'b1, 32'd5, 32'd9, 1'b0, "reset0");
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "reset1");

        // First accept right after reset, no extra latency.
        step(1'b0, 1'b1, 5398457, 90505443, 1'b0, "vec_lt");
        // Back-to-back signed accepts.
        step(1'b0, 1'b1, -4096580, 956445, 1'b0, "b2b_lt");
        step(1'b0, 1'b1, 436907954, -497843978, 1'b0, "b2b_gt");
        step(1'b0, 1'b1, -43984379, -43984379, 1'b0, "neg_eq");
        step(1'b0, 1'b1, -90319842, -28648976, 1'b0, "neg_lt");

        // Most-negative versus most-positive in both modes.
        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "bnd_s");
        step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "bnd_u");
        step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, "zero_eq");
        step(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, "mneg_eq_u");
        step(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mneg_eq_s");

        // Accept, then three idle cycles: outputs hold, out_valid low.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, "hold_acc");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, $urandom, $urandom, 1'($urandom), "hold_idle");

        // Reset in the cycle after an accept drops that result.
        step(1'b0, 1'b1, 32'h1, 32'hFFFF_FFFF, 1'b1, "pre_rst");
        step(1'b1, 1'b1, 32'h7, 32'h3, 1'b0, "rst_kill");
        step(1'b0, 1'b0, 32'h7, 32'h3, 1'b0, "post_rst");

        // Randomized traffic with biased operand patterns.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = edge_vals[$urandom_range(0, 4)]; rb = edge_vals[$urandom_range(0, 4)]; end
                default: begin ra = $urandom; rb = ra + W'($urandom_range(0, 4)) - W'(2); end
            endcase
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 ra, rb, 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
